serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Multi-cycle digit-serial adder: the successor to the single-bit full adder, generalised to WIDTH bits.
//  Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a ripple chain of full adders.
//  Valid/ready handshake on input and output; one operation in flight.
//  Sits between operand registers and the ALU result bus wherever area matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; must be >= 1
//  DIGIT  2  bits added per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, carryin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carryin    in   1      carry into bit 0
//  sub        in   1      subtract mode (present only with SERIAL_ADDER_SUB_EN)
//  out_valid  out  1      sum/carryout/overflow valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  result
//  carryout   out  1      carry out of bit WIDTH-1
//  overflow   out  1      signed (two's-complement) overflow
// BEHAVIOUR
//  - NDIG = WIDTH/DIGIT. States: IDLE -> BUSY -> DONE -> IDLE.
//  - Reset (async assert, sync release): state IDLE; sum, carryout, overflow, out_valid = 0; counters/shift regs = 0.
//  - in_ready = (state==IDLE); out_valid = (state==DONE). Both are combinational from state only.
//  - Accept at edge t when in_valid && in_ready:
//    - latch a, b into shift regs; carry reg = carryin; digit count = 0; go to BUSY.
//  - BUSY, each edge: add the low DIGIT bits of the A and B regs plus the carry reg.
//    - Shift the digit sum into sum from the MSB end; update the carry reg; shift A and B right by DIGIT.
//  - On the NDIG-th BUSY edge (count == NDIG-1): go to DONE.
//    - carryout = final carry; overflow = carry into MSB XOR carry out of MSB.
//  - Latency: out_valid rises after edge t+NDIG. Throughput: 1 op per NDIG+2 cycles with out_ready held high.
//  - DONE: sum/carryout/overflow held stable until out_valid && out_ready at an edge, then IDLE.
//    - No accept in the same cycle (in_ready low in DONE).
//  - in_valid/a/b changes while BUSY/DONE are ignored; operands are sampled only at accept.
//  - Arithmetic: sum = (a + b + carryin) mod 2^WIDTH; carryout = bit WIDTH of the full sum.
//  - Reset mid-BUSY/DONE: operation aborted, all outputs zero, IDLE; no partial result is ever presented.
//  - DIGIT == WIDTH: NDIG = 1, a single BUSY cycle.
// CONFIGURATION
//  - SERIAL_ADDER_SUB_EN defined: port sub exists, sampled at accept.
//    - sub=1: B is inverted and the effective carry-in = ~carryin (carryin=0 gives a-b; carryout=1 means no borrow).
//    - overflow uses the inverted-B operand.
//  - Undefined: no sub port; always add.
// STRUCTURE
//  - Package adder_pkg: typedef enum logic [1:0] {IDLE, BUSY, DONE} sadd_state_t.
//  - adder_pkg also holds the localparam helper for counter width: $clog2(NDIG) min 1.
//  - Sub-module digit_adder #(DIGIT): combinational ripple of DIGIT full adders.
//    - Ports: a, b, cin -> s, cout, c_msb_in (carry into top bit, for overflow).
//  - serial_adder holds the FSM, digit counter, shift registers and output registers.
// TESTING (WIDTH=8, DIGIT=2 unless noted)
//  - 0x7F+0x01, cin=0 -> sum=0x80, carryout=0, overflow=1; out_valid exactly 4 edges after accept.
//  - 0xFF+0x01, cin=0 -> sum=0x00, carryout=1, overflow=0; 0xFF+0xFF, cin=1 -> sum=0xFF, carryout=1.
//  - Backpressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, a/b wiggles ignored.
//    - out_ready high -> IDLE next edge.
//  - Reset pulse mid-BUSY (after 2 digits) -> outputs 0, IDLE.
//    - Next op 0x12+0x34 -> 0x46, carryout=0.
//  - WIDTH=1, DIGIT=1: all 8 a/b/cin combinations -> full-adder truth table (sum, carryout); random 1000 ops at WIDTH=16, DIGIT=4 vs a+b+cin.
//  - With SERIAL_ADDER_SUB_EN: 0x05-0x07, sub=1, cin=0 -> sum=0xFE, carryout=0.
//    - 0x80-0x01 -> 0x7F, overflow=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   sadd_state_t : FSM state encoding (IDLE / BUSY / DONE)
//   cnt_width()  : width of the digit counter for a given digit count (minimum 1)
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  // A single-digit configuration still needs a 1-bit counter so the
  // counter vector never collapses to zero width.
  function automatic int cnt_width(input int ndig);
    int w;
    w = $clog2(ndig);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational ripple of DIGIT full adders.
// Ports:
//   a, b      in   DIGIT  operand digits
//   cin       in   1      carry into bit 0
//   s         out  DIGIT  digit sum
//   cout      out  1      carry out of bit DIGIT-1
//   c_msb_in  out  1      carry into bit DIGIT-1 (used for signed overflow)
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, DIGIT bits per clock, WIDTH-bit operands.
// One operation in flight, valid/ready handshake on both sides.
// Optional macro SERIAL_ADDER_SUB_EN adds the 'sub' port (a - b mode).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (a, b, carryin[, sub])
//   out_valid/ out_ready result handshake (sum, carryout, overflow)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | adding one digit per clock
// DONE  | result held, out_valid high until out_ready
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  generate
    if ((WIDTH < 1) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  sadd_state_t      state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic [WIDTH-1:0] sum_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + ~carryin, so carryin=0 yields a plain subtract.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~carryin : carryin;
`else
  assign b_eff   = b;
  assign cin_eff = carryin;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .s        (dsum),
    .cout     (dcout),
    .c_msb_in (dcmsb)
  );

  // Digits enter at the MSB end; after NDIG shifts the first digit sits at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_one_digit
      assign sum_nxt = dsum;
    end else begin : g_multi_digit
      assign sum_nxt = {dsum, sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b_eff;
            carry    <= cin_eff;
            cnt      <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sum   <= sum_nxt;
          carry <= dcout;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NDIG - 1)) begin
            carryout <= dcout;
            overflow <= dcmsb ^ dcout;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk;
  logic rst_n;

  // WIDTH=8, DIGIT=2
  logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
  logic [7:0] a8, b8, s8;
  // WIDTH=1, DIGIT=1
  logic       iv1, ir1, ov1, or1, cin1, sub1, co1, of1;
  logic [0:0] a1, b1, s1;
  // WIDTH=16, DIGIT=4
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
  logic [15:0] a16, b16, s16;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .carryin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carryout(co8), .overflow(of8)
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .carryin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(ov1), .out_ready(or1), .sum(s1), .carryout(co1), .overflow(of1)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .carryin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .out_valid(ov16), .out_ready(or16), .sum(s16), .carryout(co16), .overflow(of16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts and ends 1 time unit after a rising edge. Leaves result un-consumed.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input logic isub, output int lat);
    a8 = ia; b8 = ib; cin8 = ic; sub8 = isub; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    repeat (3) @(posedge clk);
    #3;
    n_checks++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", s8); end
    n_checks++; if ({co8, of8} !== 2'b00) begin n_fail++; $display("FAIL reset_co_ov got %b want 00", {co8, of8}); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov8); end
    n_checks++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir8); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    run8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", lat); end
    n_checks++; if (s8 !== 8'h80) begin n_fail++; $display("FAIL add_7f_01_sum got %h want 80", s8); end
    n_checks++; if ({co8, of8} !== 2'b01) begin n_fail++; $display("FAIL add_7f_01_co_ov got %b want 01", {co8, of8}); end
    n_checks++; if (ir8 !== 1'b0) begin n_fail++; $display("FAIL add_in_ready_done got %b want 0", ir8); end
    consume8();
    n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin n_fail++; $display("FAIL add_idle_after_consume got ir=%b ov=%b want 1 0", ir8, ov8); end

    run8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    n_checks++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL add_ff_01_sum got %h want 00", s8); end
    n_checks++; if ({co8, of8} !== 2'b10) begin n_fail++; $display("FAIL add_ff_01_co_ov got %b want 10", {co8, of8}); end
    consume8();

    run8(8'hFF, 8'hFF, 1'b1, 1'b0, lat);
    n_checks++; if (s8 !== 8'hFF) begin n_fail++; $display("FAIL add_ff_ff_c1_sum got %h want ff", s8); end
    n_checks++; if ({co8, of8} !== 2'b10) begin n_fail++; $display("FAIL add_ff_ff_c1_co_ov got %b want 10", {co8, of8}); end
    consume8();
  endtask

  task automatic test_backpressure();
    int lat;
    // 0x55 + 0x2A + 1 = 0x80: carryout 0, signed overflow 1
    run8(8'h55, 8'h2A, 1'b1, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1; a8 = 8'(i * 37 + 3); b8 = 8'(~i); cin8 = i[0];
      @(posedge clk); #1;
      n_checks++;
      if (s8 !== 8'h80 || co8 !== 1'b0 || of8 !== 1'b1 || ov8 !== 1'b1 || ir8 !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc %0d got sum=%h co=%b ovf=%b ov=%b ir=%b want 80 0 1 1 0",
                 i, s8, co8, of8, ov8, ir8);
      end
    end
    iv8 = 1'b0;
    consume8();
    n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin n_fail++; $display("FAIL backpressure_release got ir=%b ov=%b want 1 0", ir8, ov8); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_reset got sum=%h co=%b ovf=%b ov=%b ir=%b want 00 0 0 0 1", s8, co8, of8, ov8, ir8);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin n_fail++; $display("FAIL mid_busy_idle got ov=%b ir=%b want 0 1", ov8, ir8); end
    run8(8'h12, 8'h34, 1'b0, 1'b0, lat);
    n_checks++; if (s8 !== 8'h46 || co8 !== 1'b0) begin n_fail++; $display("FAIL after_reset_op got sum=%h co=%b want 46 0", s8, co8); end
    consume8();
  endtask

  task automatic test_width1();
    logic [2:0] v;
    logic       es, ec;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      es = v[2] ^ v[1] ^ v[0];
      ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 10) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (lat !== 1 || s1 !== es || co1 !== ec) begin
        n_fail++;
        $display("FAIL width1_fa abc=%b got lat=%0d s=%b co=%b want 1 %b %b", v, lat, s1, co1, es, ec);
      end
      or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
    end
  endtask

  task automatic test_random16();
    logic [16:0] exp;
    logic        eov;
    int          lat;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      exp = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
      eov = (a16[15] == b16[15]) && (exp[15] != a16[15]);
      iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      lat = 0;
      while (!ov16 && lat < 20) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (lat !== 4 || {co16, s16} !== exp || of16 !== eov) begin
        n_fail++;
        $display("FAIL random16 %h+%h+%b got lat=%0d co=%b sum=%h ovf=%b want 4 %b %h %b",
                 a16, b16, cin16, lat, co16, s16, of16, exp[16], exp[15:0], eov);
      end
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    run8(8'h05, 8'h07, 1'b0, 1'b1, lat);
    n_checks++; if (s8 !== 8'hFE || co8 !== 1'b0) begin n_fail++; $display("FAIL sub_05_07 got sum=%h co=%b want fe 0", s8, co8); end
    consume8();
    run8(8'h80, 8'h01, 1'b0, 1'b1, lat);
    n_checks++; if (s8 !== 8'h7F || co8 !== 1'b1 || of8 !== 1'b1) begin n_fail++; $display("FAIL sub_80_01 got sum=%h co=%b ovf=%b want 7f 1 1", s8, co8, of8); end
    consume8();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_busy();
    test_width1();
    test_random16();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
